// File: rtl/bram_tdp_be.sv
// True dual-port byte-enable block RAM with configurable read latency and cross-port collision flag.
// Optional collision counter: define BRAM_TDP_COLLISION_CNT_EN to add the collision_cnt port.
module bram_tdp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_DEPTH = 2**ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             a_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_data_in,
  output logic [DATA_WIDTH-1:0]            a_data_out,
  output logic                             a_valid,
  input  logic                             b_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]            b_data_in,
  output logic [DATA_WIDTH-1:0]            b_data_out,
  output logic                             b_valid,
`ifdef BRAM_TDP_COLLISION_CNT_EN
  output logic                             collision,
  output logic [15:0]                      collision_cnt
`else
  output logic                             collision
`endif
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  logic [DATA_WIDTH-1:0] r_a_dat_p [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_b_dat_p [RD_LATENCY];
  logic [RD_LATENCY-1:0] r_a_vld_p;
  logic [RD_LATENCY-1:0] r_b_vld_p;
  logic                  r_collision;

  logic [IW-1:0]         w_a_idx, w_b_idx;
  logic                  w_a_inr, w_b_inr;
  logic                  w_a_wr, w_b_wr;
  logic [DATA_WIDTH-1:0] w_a_old, w_b_old;
  logic [DATA_WIDTH-1:0] w_a_rdat, w_b_rdat;
  logic                  w_a_rvld, w_b_rvld;
  logic                  w_coll;

  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] din,
    input logic [NB-1:0]         we
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  assign w_a_idx = a_addr[IW-1:0];
  assign w_b_idx = b_addr[IW-1:0];
  assign w_a_inr = 32'(a_addr) < 32'(DATA_DEPTH);
  assign w_b_inr = 32'(b_addr) < 32'(DATA_DEPTH);
  assign w_a_wr  = a_en & (|a_we) & w_a_inr;
  assign w_b_wr  = b_en & (|b_we) & w_b_inr;
  assign w_a_old = w_a_inr ? r_mem[w_a_idx] : '0;
  assign w_b_old = w_b_inr ? r_mem[w_b_idx] : '0;

  // Only a port's own write is visible in WRITE_FIRST; the other port always reads the pre-write word.
  assign w_a_rdat = (WRITE_MODE == 1 && w_a_wr) ? f_merge(w_a_old, a_data_in, a_we) : w_a_old;
  assign w_b_rdat = (WRITE_MODE == 1 && w_b_wr) ? f_merge(w_b_old, b_data_in, b_we) : w_b_old;
  assign w_a_rvld = a_en & ~((WRITE_MODE == 2) & (|a_we));
  assign w_b_rvld = b_en & ~((WRITE_MODE == 2) & (|b_we));

  assign w_coll = a_en & b_en & (a_addr == b_addr) & ((|a_we) | (|b_we));

  // Array write: B's lane assignment comes last so it wins on a shared byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        if (w_a_wr && a_we[i])
          r_mem[w_a_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (w_b_wr && b_we[i])
          r_mem[w_b_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage 1 is the array read register, later stages only forward; data moves only with valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_vld_p <= '0;
      r_b_vld_p <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_a_dat_p[i] <= '0;
        r_b_dat_p[i] <= '0;
      end
    end else begin
      r_a_vld_p[0] <= w_a_rvld;
      r_b_vld_p[0] <= w_b_rvld;
      if (w_a_rvld) r_a_dat_p[0] <= w_a_rdat;
      if (w_b_rvld) r_b_dat_p[0] <= w_b_rdat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_a_vld_p[i] <= r_a_vld_p[i-1];
        r_b_vld_p[i] <= r_b_vld_p[i-1];
        if (r_a_vld_p[i-1]) r_a_dat_p[i] <= r_a_dat_p[i-1];
        if (r_b_vld_p[i-1]) r_b_dat_p[i] <= r_b_dat_p[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_collision <= 1'b0;
    else     r_collision <= w_coll;
  end

`ifdef BRAM_TDP_COLLISION_CNT_EN
  logic [15:0] r_coll_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_coll_cnt <= '0;
    else if (w_coll && r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
  end

  assign collision_cnt = r_coll_cnt;
`endif

  assign a_data_out = r_a_dat_p[RD_LATENCY-1];
  assign a_valid    = r_a_vld_p[RD_LATENCY-1];
  assign b_data_out = r_b_dat_p[RD_LATENCY-1];
  assign b_valid    = r_b_vld_p[RD_LATENCY-1];
  assign collision  = r_collision;

endmodule
